// File: rtl/regop_pkg.sv
// ============================================================================
//  regop_pkg
//  Shared opcode/state encodings and width defaults for reg_op_sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package regop_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_AND  = 2'd2,
    OP_MOVI = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regop_alu.sv
// ============================================================================
//  regop_alu
//  Combinational ADD/SUB/AND/MOVI with carry/borrow; REGOP_SAT_EN saturates.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module regop_alu
  import regop_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_borrow;

  assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff   = i_a - i_b;
  assign w_borrow = (i_a < i_b);

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (op_e'(i_op))
      OP_ADD: begin
        o_carry = w_sum[DATA_W];
`ifdef REGOP_SAT_EN
        o_result = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
        o_result = w_sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        o_carry = w_borrow;
`ifdef REGOP_SAT_EN
        o_result = w_borrow ? '0 : w_diff;
`else
        o_result = w_diff;
`endif
      end
      OP_AND:  o_result = i_a & i_b;
      OP_MOVI: o_result = i_imm;
      default: o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reg_op_sequencer.sv
// ============================================================================
//  reg_op_sequencer
//  4-phase (IDLE/READ/EXEC/WRITE) register-bank op sequencer, 1 op / 4 cycles.
//  Optional macro REGOP_SAT_EN: saturating ADD/SUB (handled in regop_alu).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_op_sequencer
  import regop_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src0,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] bank_add_rd0,
  output logic [ADDR_W-1:0] bank_add_rd1,
  input  logic [DATA_W-1:0] bank_rd0,
  input  logic [DATA_W-1:0] bank_rd1,
  output logic [ADDR_W-1:0] bank_add_wr,
  output logic [DATA_W-1:0] bank_wr_data,
  output logic              bank_wr_en,
  output logic              busy,
  output logic              done,
  output logic              flag_carry
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_EXEC  = ST_EXEC;
  localparam logic [1:0] S_WRITE = ST_WRITE;

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_src0;
  logic [ADDR_W-1:0] r_src1;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_carry;

  logic [DATA_W-1:0] w_result;
  logic              w_carry;

  regop_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_imm    (r_imm),
    .o_result (w_result),
    .o_carry  (w_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_dst    <= '0;
      r_src0   <= '0;
      r_src1   <= '0;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_dst   <= cmd_dst;
            r_src0  <= cmd_src0;
            r_src1  <= cmd_src1;
            r_imm   <= cmd_imm;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // Operands sampled before this op's own write, so dst==src sees the old value.
          r_a     <= bank_rd0;
          r_b     <= bank_rd1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_result;
          r_carry  <= w_carry;
          r_state  <= S_WRITE;
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_WRITE);
  assign bank_wr_en   = (r_state != S_WRITE);
  assign bank_add_rd0 = r_src0;
  assign bank_add_rd1 = r_src1;
  assign bank_add_wr  = r_dst;
  assign bank_wr_data = r_result;
  assign flag_carry   = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
// ============================================================================
//  tb_reg_op_sequencer
//  Self-checking bench: external bank, phase-count reference model, directed + random ops.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_op_sequencer;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_dst = '0, cmd_src0 = '0, cmd_src1 = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [AW-1:0] bank_add_rd0, bank_add_rd1, bank_add_wr;
  logic [DW-1:0] bank_rd0, bank_rd1, bank_wr_data;
  logic          bank_wr_en, busy, done, flag_carry;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run_chk = 1'b0;

  reg_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_imm(cmd_imm),
    .bank_add_rd0(bank_add_rd0), .bank_add_rd1(bank_add_rd1),
    .bank_rd0(bank_rd0), .bank_rd1(bank_rd1),
    .bank_add_wr(bank_add_wr), .bank_wr_data(bank_wr_data), .bank_wr_en(bank_wr_en),
    .busy(busy), .done(done), .flag_carry(flag_carry)
  );

  always #5 clock = ~clock;

  // External register bank driven by the DUT; shares the reset so a reset edge blocks a commit.
  logic [DW-1:0] tb_bank [4] = '{default: '0};
  assign bank_rd0 = tb_bank[bank_add_rd0];
  assign bank_rd1 = tb_bank[bank_add_rd1];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && bank_wr_en === 1'b0) tb_bank[bank_add_wr] <= bank_wr_data;
  end

  // Reference model: cycles since acceptance plus an architectural register file.
  logic [DW-1:0] m_regs [4] = '{default: '0};
  int            m_phase = 0;
  logic [1:0]    m_op = '0;
  logic [AW-1:0] m_dst = '0, m_src0 = '0, m_src1 = '0;
  logic [DW-1:0] m_imm = '0, m_res = '0;
  logic          m_flag = 1'b0;

  function automatic void ref_op(input logic [1:0] op, input logic [DW-1:0] a, b, imm,
                                 output logic [DW-1:0] res, output logic cy);
    int sa, sb;
    bit sat;
`ifdef REGOP_SAT_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'd0: begin
        cy  = (sa + sb) > 255;
        res = (sat && cy) ? 8'hFF : 8'((sa + sb) % 256);
      end
      2'd1: begin
        cy  = sa < sb;
        res = (sat && cy) ? 8'h00 : 8'((sa - sb + 256) % 256);
      end
      2'd2: begin cy = 1'b0; res = a & b; end
      default: begin cy = 1'b0; res = imm; end
    endcase
  endfunction

  always @(posedge clock) begin
    logic [DW-1:0] r;
    logic c;
    run_chk = 1'b1;
    if (reset) begin
      m_phase = 0; m_op = '0; m_dst = '0; m_src0 = '0; m_src1 = '0;
      m_imm = '0; m_res = '0; m_flag = 1'b0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_op = cmd_op; m_dst = cmd_dst; m_src0 = cmd_src0; m_src1 = cmd_src1;
          m_imm = cmd_imm; m_phase = 1;
        end
        1: m_phase = 2;
        2: begin
          ref_op(m_op, m_regs[m_src0], m_regs[m_src1], m_imm, r, c);
          m_res = r; m_flag = c; m_phase = 3;
        end
        default: begin m_regs[m_dst] = m_res; m_phase = 0; end
      endcase
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clock) begin
    if (run_chk) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 3));
      chk("bank_wr_en", 32'(bank_wr_en), 32'(m_phase != 3));
      chk("bank_add_wr", 32'(bank_add_wr), 32'(m_dst));
      chk("bank_wr_data", 32'(bank_wr_data), 32'(m_res));
      chk("bank_add_rd0", 32'(bank_add_rd0), 32'(m_src0));
      chk("bank_add_rd1", 32'(bank_add_rd1), 32'(m_src1));
      chk("flag_carry", 32'(flag_carry), 32'(m_flag));
      for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), 32'(tb_bank[i]), 32'(m_regs[i]));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] dst, s0, s1,
                      input logic [DW-1:0] imm, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src0 = s0; cmd_src1 = s1; cmd_imm = imm;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout: cmd_ready=%b expected 1", cmd_ready);
    end
    acc = cyc + 1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [AW-1:0] dst, s0, s1,
                        input logic [DW-1:0] imm);
    int a;
    send(op, dst, s0, s1, imm, a);
    repeat (3) @(negedge clock);
  endtask

`ifdef REGOP_SAT_EN
  localparam logic [7:0] EXP_ADD  = 8'hFF;
  localparam logic [7:0] EXP_SUB  = 8'h00;
  localparam logic [7:0] EXP_DEP  = 8'hFF;
`else
  localparam logic [7:0] EXP_ADD  = 8'h10;
  localparam logic [7:0] EXP_SUB  = 8'hFE;
  localparam logic [7:0] EXP_DEP  = 8'h10;
`endif

  initial begin
    int a0, a1, a2;
    repeat (2) @(negedge clock);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_wr_en", 32'(bank_wr_en), 32'h1);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_flag", 32'(flag_carry), 32'h0);
    reset = 1'b0;

    // MOVI timing: strobe low only in the third cycle after acceptance
    send(2'd3, 2'd2, 2'd0, 2'd0, 8'h5A, a0);
    chk("movi_ph1_done", 32'(done), 32'h0);
    @(negedge clock);
    chk("movi_ph2_wr_en", 32'(bank_wr_en), 32'h1);
    @(negedge clock);
    chk("movi_wr_en", 32'(bank_wr_en), 32'h0);
    chk("movi_done", 32'(done), 32'h1);
    chk("movi_add_wr", 32'(bank_add_wr), 32'h2);
    chk("movi_wr_data", 32'(bank_wr_data), 32'h5A);
    @(negedge clock);
    chk("movi_wr_en_after", 32'(bank_wr_en), 32'h1);
    chk("movi_reg2", 32'(tb_bank[2]), 32'h5A);

    run_op(2'd3, 2'd0, 2'd0, 2'd0, 8'hF0);
    run_op(2'd3, 2'd1, 2'd0, 2'd0, 8'h20);
    run_op(2'd0, 2'd3, 2'd0, 2'd1, 8'h00);
    chk("add_reg3", 32'(tb_bank[3]), 32'(EXP_ADD));
    chk("add_carry", 32'(flag_carry), 32'h1);

    run_op(2'd3, 2'd0, 2'd0, 2'd0, 8'h05);
    run_op(2'd3, 2'd1, 2'd0, 2'd0, 8'h07);
    run_op(2'd1, 2'd0, 2'd0, 2'd1, 8'h00);
    chk("sub_reg0", 32'(tb_bank[0]), 32'(EXP_SUB));
    chk("sub_carry", 32'(flag_carry), 32'h1);

    // Back-to-back with cmd_valid effectively held high
    run_op(2'd3, 2'd1, 2'd0, 2'd0, 8'hCC);
    run_op(2'd3, 2'd2, 2'd0, 2'd0, 8'hAA);
    send(2'd2, 2'd1, 2'd1, 2'd2, 8'h00, a0);
    send(2'd0, 2'd0, 2'd1, 2'd1, 8'h00, a1);
    send(2'd3, 2'd3, 2'd0, 2'd0, 8'h3C, a2);
    repeat (3) @(negedge clock);
    chk("b2b_gap1", 32'(a1 - a0), 32'd4);
    chk("b2b_gap2", 32'(a2 - a1), 32'd4);
    chk("and_reg1", 32'(tb_bank[1]), 32'h88);
    chk("dep_reg0", 32'(tb_bank[0]), 32'(EXP_DEP));
    chk("b2b_reg3", 32'(tb_bank[3]), 32'h3C);

    // Reset during WRITE discards the op
    run_op(2'd0, 2'd0, 2'd1, 2'd1, 8'h00);
    send(2'd3, 2'd2, 2'd0, 2'd0, 8'h33, a0);
    repeat (2) @(negedge clock);
    chk("pre_rst_done", 32'(done), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstw_wr_en", 32'(bank_wr_en), 32'h1);
    chk("rstw_done", 32'(done), 32'h0);
    chk("rstw_reg2", 32'(tb_bank[2]), 32'hAA);
    chk("rstw_flag", 32'(flag_carry), 32'h0);

    // Reset together with cmd_valid must not accept
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd3; cmd_dst = 2'd2; cmd_imm = 8'h77;
    @(negedge clock);
    reset = 1'b0; cmd_valid = 1'b0;
    chk("rstv_busy", 32'(busy), 32'h0);
    repeat (4) @(negedge clock);
    chk("rstv_reg2", 32'(tb_bank[2]), 32'hAA);

    for (int k = 0; k < 150; k++) begin
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), a0);
      if ($urandom_range(0, 24) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
      repeat ($urandom_range(0, 4)) @(negedge clock);
    end
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 8, register data width.
REQ-002 ADDR_W, 2, register address width (4 registers).
REQ-003 Ports SHALL be (name direction width meaning), clock and reset first: clock in 1 sole clock, rising edge.
REQ-004 reset in 1: synchronous, active-high.
REQ-005 cmd_valid in 1: command offered. cmd_ready out 1: command accepted when both high at a rising edge.
REQ-006 cmd_op in 2: operation (ADD, SUB, AND, MOVI). cmd_dst, cmd_src0, cmd_src1 in ADDR_W each: destination and source registers. cmd_imm in DATA_W: immediate for MOVI.
REQ-007 bank_add_rd0, bank_add_rd1 out ADDR_W: bank read addresses. bank_rd0, bank_rd1 in DATA_W: combinational bank read data.
REQ-008 bank_add_wr out ADDR_W, bank_wr_data out DATA_W: bank write address and data. bank_wr_en out 1: bank write strobe, active-low (0 = write).
REQ-009 busy out 1: FSM not IDLE. done out 1: one-cycle completion pulse. flag_carry out 1: carry/borrow of last completed op.

Function
REQ-010 FSM states SHALL be IDLE, READ, EXEC, WRITE; transitions IDLE->READ on handshake, READ->EXEC, EXEC->WRITE, WRITE->IDLE, unconditional.
REQ-011 cmd_ready SHALL be 1 only in IDLE; fields are latched at the handshake edge; cmd_valid outside IDLE is ignored (no buffering).
REQ-012 bank_add_rd0/rd1 SHALL equal the latched src0/src1 in all states; operands are captured from bank_rd0/rd1 at the READ->EXEC edge.
REQ-013 Result and carry SHALL be computed in EXEC and registered at the EXEC->WRITE edge.
REQ-014 ADD: src0+src1, carry = bit DATA_W of the sum. SUB: src0-src1, carry = borrow (src0<src1). AND: bitwise, carry=0. MOVI: cmd_imm, carry=0; MOVI still passes through READ (fixed latency).
REQ-015 In WRITE, bank_wr_en SHALL be 0 for exactly that cycle, bank_add_wr = latched dst, bank_wr_data = result; the bank commits at the WRITE->IDLE edge; bank_wr_en = 1 in all other states.
REQ-016 done SHALL be 1 exactly during WRITE; flag_carry updates at the EXEC->WRITE edge and holds until the next op's EXEC->WRITE edge.
REQ-017 Latency: handshake at edge T0 -> bank write at edge T0+3; next handshake possible at edge T0+4 (throughput 1 op / 4 cycles).
REQ-018 dst equal to src0 or src1 SHALL use the pre-write value (read precedes write).
REQ-019 Back-to-back dependent ops SHALL see the prior result (write committed before next READ).

Reset
REQ-020 reset at any edge SHALL force IDLE, bank_wr_en=1, done=0, busy=0, flag_carry=0, latched fields, addresses, wr_data and result=0.
REQ-021 reset during WRITE SHALL win: no further write strobe after the reset edge; an in-flight op is discarded without done.
REQ-022 reset and cmd_valid together SHALL not accept the command.

Configuration
REQ-023 Macro REGOP_SAT_EN defined: ADD overflow saturates to all-ones, SUB underflow saturates to zero; flag_carry still reports overflow/borrow.
REQ-024 REGOP_SAT_EN undefined: ADD/SUB wrap modulo 2^DATA_W.

Structure
REQ-025 Package regop_pkg SHALL hold the opcode enum (ADD=0, SUB=1, AND=2, MOVI=3), the FSM state enum and DATA_W/ADDR_W defaults.
REQ-026 One sub-module regop_alu SHALL implement the combinational op/carry/saturation logic; FSM and registers stay in reg_op_sequencer.

Verification
REQ-027 MOVI dst=2 imm=0x5A after reset -> bank_wr_en low exactly one cycle, add_wr=2, wr_data=0x5A, done at T0+3, reg2=0x5A.
REQ-028 r0=0xF0, r1=0x20, ADD dst=3 -> wrap: 0x10, carry=1; with REGOP_SAT_EN: 0xFF, carry=1.
REQ-029 r0=0x05, r1=0x07, SUB dst=0 src0=0 src1=1 -> r0=0xFE (SAT: 0x00), carry=1, read-before-write honoured.
REQ-030 cmd_valid held high continuously with 3 ops -> cmd_ready high only in IDLE, accepts at T0, T0+4, T0+8, no op lost or duplicated.
REQ-031 reset asserted in WRITE -> bank_wr_en=1, done=0 on next cycle, target register unchanged after the reset edge, flag_carry=0.
REQ-032 AND r1=0xCC, r2=0xAA dst=1 then ADD dst=0 src0=1 src1=1 -> r1=0x88, r0=0x10, carry=1.
